branch_predictor: RTL and testbench

Dynamic branch direction predictor for the pipelined RISC-V core. It holds a direct-mapped table of 2-bit saturating counters. The table is read combinationally in Fetch to produce PCSrcPredF for the branch control unit, and updated from Execute with the resolved outcome PCSrcResE. It is the stateful source of every taken/untaken prediction that the branch control unit later confirms or rolls back.

---
 rtl/branch_pkg.sv | 30 +++
 rtl/sat_counter_2b.sv | 35 +++
 rtl/branch_predictor.sv | 80 ++++++++
 tb/tb_branch_predictor.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch direction predictor:
// 2-bit saturating counter encoding and its reset value.
package branch_pkg;

    typedef enum logic [1:0] {
        STRONG_UNTAKEN = 2'b00,
        WEAK_UNTAKEN   = 2'b01,
        WEAK_TAKEN     = 2'b10,
        STRONG_TAKEN   = 2'b11
    } cnt_state_e;

    localparam cnt_state_e CNT_RESET = WEAK_UNTAKEN;

    // Saturating step: never wraps 11 -> 00 or 00 -> 11.
    function automatic cnt_state_e cnt_step(input cnt_state_e cur, input logic taken);
        logic [1:0] raw;
        raw = cur;
        if (taken) begin
            if (cur != STRONG_TAKEN) begin
                raw = raw + 2'd1;
            end
        end else begin
            if (cur != STRONG_UNTAKEN) begin
                raw = raw - 2'd1;
            end
        end
        return cnt_state_e'(raw);
    endfunction

endpackage

// File: rtl/sat_counter_2b.sv
// One 2-bit saturating direction counter with async active-high reset,
// update enable and direction (1 = taken) inputs.
module sat_counter_2b
    import branch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       taken,
    output logic [1:0] cnt
);

    cnt_state_e cnt_q;
    cnt_state_e cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = cnt_step(cnt_q, taken);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the
    // combinational next-state above assigns its default first so no latch forms.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= CNT_RESET;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped table of 2-bit saturating counters: combinational read in
// Fetch, one-entry update from Execute. Define GSHARE_EN to XOR a global
// history register into both indexes (gshare); otherwise bimodal.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int INDEX_WIDTH = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic [31:0] PCE,
    input  logic        BranchE,
    input  logic        StallE,
    input  logic        PCSrcResE,
    output logic        PCSrcPredF
);

    localparam int DEPTH = 1 << INDEX_WIDTH;

    logic [INDEX_WIDTH-1:0] rd_idx;
    logic [INDEX_WIDTH-1:0] upd_idx;
    logic                   upd_en;
    logic [DEPTH-1:0]       upd_sel;
    logic [1:0]             cnt_tbl [DEPTH];

    // A stalled branch trains only once, on the cycle its stall releases.
    assign upd_en = BranchE && !StallE;

`ifdef GSHARE_EN
    logic [INDEX_WIDTH-1:0] ghr_q;
    logic [INDEX_WIDTH-1:0] ghr_d;

    always_comb begin
        ghr_d = ghr_q;
        if (upd_en) begin
            ghr_d = {ghr_q[INDEX_WIDTH-2:0], PCSrcResE};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    // Both sides hash with the pre-shift history; no per-branch snapshot.
    assign rd_idx  = PCF[INDEX_WIDTH+1:2] ^ ghr_q;
    assign upd_idx = PCE[INDEX_WIDTH+1:2] ^ ghr_q;
`else
    assign rd_idx  = PCF[INDEX_WIDTH+1:2];
    assign upd_idx = PCE[INDEX_WIDTH+1:2];
`endif

    always_comb begin
        upd_sel          = '0;
        upd_sel[upd_idx] = upd_en;
    end

    // Every entry is a resettable flop pair so reset can clear all history at once.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cnt
        sat_counter_2b u_cnt (
            .clk   (clk),
            .reset (reset),
            .en    (upd_sel[i]),
            .taken (PCSrcResE),
            .cnt   (cnt_tbl[i])
        );
    end

    assign PCSrcPredF = cnt_tbl[rd_idx][1];

    // Upper PC bits alias by design and the byte offset never selects an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PCF[31:INDEX_WIDTH+2], PCF[1:0],
                              PCE[31:INDEX_WIDTH+2], PCE[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default bimodal build,
// INDEX_WIDTH = 6) with hand-computed expected predictions.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] PCF;
    logic [31:0] PCE;
    logic        BranchE;
    logic        StallE;
    logic        PCSrcResE;
    logic        PCSrcPredF;

    int errors = 0;
    int checks = 0;

    branch_predictor #(.INDEX_WIDTH(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .PCF        (PCF),
        .PCE        (PCE),
        .BranchE    (BranchE),
        .StallE     (StallE),
        .PCSrcResE  (PCSrcResE),
        .PCSrcPredF (PCSrcPredF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Look up PCF mid-cycle and compare the prediction.
    task automatic expect_pred(input string tag, input logic [31:0] pc, input logic exp);
        PCF = pc;
        #1;
        check(tag, PCSrcPredF, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        BranchE   = 1'b0;
        StallE    = 1'b0;
        PCSrcResE = 1'b0;
        reset     = 1'b1;
        #2;
        reset     = 1'b0;
    endtask

    // One qualifying update, inputs set up at the falling edge.
    task automatic train(input logic [31:0] pc, input logic taken);
        @(negedge clk);
        PCE       = pc;
        BranchE   = 1'b1;
        StallE    = 1'b0;
        PCSrcResE = taken;
        @(posedge clk);
        #1;
        BranchE   = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        PCF       = '0;
        PCE       = '0;
        BranchE   = 1'b0;
        StallE    = 1'b0;
        PCSrcResE = 1'b0;
        #12;
        reset = 1'b0;

        // 1: every entry resets to WEAK_UNTAKEN.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            expect_pred($sformatf("reset_sweep_%0d", i), 32'(i * 4), 1'b0);
        end

        // 2: one taken update moves 01 -> 10; alias shares the entry.
        do_reset();
        train(32'h104, 1'b1);
        expect_pred("train_taken_104", 32'h104, 1'b1);
        expect_pred("alias_004",       32'h004, 1'b1);
        expect_pred("neighbour_108",   32'h108, 1'b0);

        // 3: saturation and hysteresis.
        do_reset();
        repeat (3) train(32'h104, 1'b1);
        expect_pred("sat_taken_11", 32'h104, 1'b1);
        train(32'h104, 1'b0);
        expect_pred("hyst_11_to_10", 32'h104, 1'b1);
        train(32'h104, 1'b0);
        expect_pred("hyst_10_to_01", 32'h104, 1'b0);
        repeat (4) train(32'h104, 1'b0);
        expect_pred("sat_untaken_00", 32'h104, 1'b0);
        train(32'h104, 1'b1);
        expect_pred("hyst_00_to_01", 32'h104, 1'b0);
        train(32'h104, 1'b1);
        expect_pred("step_01_to_10", 32'h104, 1'b1);

        // 4: stall and BranchE qualification.
        do_reset();
        @(negedge clk);
        PCE       = 32'h104;
        BranchE   = 1'b1;
        StallE    = 1'b1;
        PCSrcResE = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        expect_pred("stalled_no_update", 32'h104, 1'b0);
        @(negedge clk);
        BranchE = 1'b0;
        StallE  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_pred("no_branch_no_update", 32'h104, 1'b0);
        train(32'h104, 1'b1);
        expect_pred("stall_release_once", 32'h104, 1'b1);

        // 5: read-during-write returns the old value.
        do_reset();
        @(negedge clk);
        PCF       = 32'h104;
        PCE       = 32'h104;
        BranchE   = 1'b1;
        StallE    = 1'b0;
        PCSrcResE = 1'b1;
        #1;
        check("rdw_update_cycle_old", PCSrcPredF, 1'b0);
        @(posedge clk);
        #1;
        BranchE = 1'b0;
        check("rdw_next_cycle_new", PCSrcPredF, 1'b1);

        // 6: asynchronous reset mid-training discards history.
        do_reset();
        repeat (2) train(32'h104, 1'b1);
        expect_pred("pre_reset_taken", 32'h104, 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_immediate", PCSrcPredF, 1'b0);
        BranchE   = 1'b1;
        PCSrcResE = 1'b1;
        PCE       = 32'h104;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        BranchE = 1'b0;
        expect_pred("no_update_in_reset", 32'h104, 1'b0);
        train(32'h104, 1'b0);
        expect_pred("post_reset_01_to_00", 32'h104, 1'b0);
        train(32'h104, 1'b1);
        expect_pred("post_reset_00_to_01", 32'h104, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
